// File: rtl/conv_accumulator.sv
// Sums N_TERMS sign-magnitude products per kernel window and emits one saturated
// sign-magnitude result over valid/ready. Optional output ReLU: define CONV_ACC_RELU_EN.
module conv_accumulator #(
   parameter int DATA_WIDTH  = 32,
   parameter int FIXED_POINT = 16,
   parameter int N_TERMS     = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy
);

   localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   // Headroom for N_TERMS full-scale magnitudes plus a sign bit.
   localparam int ACC_W = DATA_WIDTH + $clog2(N_TERMS) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
   localparam logic [ACC_W-1:0] MAG_MAX  = (ACC_W'(1) << (DATA_WIDTH - 1)) - ACC_W'(1);

   generate
      if (N_TERMS < 1) begin : g_bad_terms
         $error("conv_accumulator: N_TERMS must be at least 1");
      end
      if (FIXED_POINT < 0 || FIXED_POINT >= DATA_WIDTH) begin : g_bad_fp
         $error("conv_accumulator: FIXED_POINT must lie within the word");
      end
   endgenerate

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                  state_q,     state_d;
   logic [ACC_W-1:0]        acc_q,       acc_d;
   logic [CNT_W-1:0]        count_q,     count_d;
   logic                    in_ready_q,  in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
   logic                    busy_q,      busy_d;

   logic [ACC_W-1:0]        term_mag;
   logic [ACC_W-1:0]        term;
   logic [ACC_W-1:0]        sum;
   logic                    sum_neg;
   logic [ACC_W-1:0]        sum_abs;
   logic [DATA_WIDTH-2:0]   sat_mag;
   logic [DATA_WIDTH-1:0]   result;
   logic                    accept;

   // Datapath: sign-magnitude in, two's complement accumulate, sign-magnitude out.
   always_comb begin
      term_mag = ACC_W'(in_data[DATA_WIDTH-2:0]);
      term     = in_data[DATA_WIDTH-1] ? (~term_mag + ACC_W'(1)) : term_mag;
      sum      = acc_q + term;
      sum_neg  = sum[ACC_W-1];
      sum_abs  = sum_neg ? (~sum + ACC_W'(1)) : sum;
      sat_mag  = (sum_abs > MAG_MAX) ? {(DATA_WIDTH-1){1'b1}} : sum_abs[DATA_WIDTH-2:0];
`ifdef CONV_ACC_RELU_EN
      result   = sum_neg ? '0 : {1'b0, sat_mag};
`else
      // A zero sum never has sum_neg set, so -0 cannot be produced.
      result   = {sum_neg, sat_mag};
`endif
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      accept      = in_valid && in_ready_q;

      case (state_q)
         ACCUM: begin
            if (accept) begin
               if (count_q == LAST_CNT) begin
                  acc_d       = '0;
                  count_d     = '0;
                  out_data_d  = result;
                  out_valid_d = 1'b1;
                  in_ready_d  = 1'b0;
                  state_d     = HOLD;
               end else begin
                  acc_d   = sum;
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            // Input stays stalled on the handoff cycle; accepting resumes next cycle.
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase

      busy_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed self-checking bench for conv_accumulator (default parameters).
// Expectations follow CONV_ACC_RELU_EN when the bench is built with it defined.
module tb_conv_accumulator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] pat [9];

   conv_accumulator #(
      .DATA_WIDTH (32),
      .FIXED_POINT(16),
      .N_TERMS    (9)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one beat and returns just after the edge that consumed it.
   task automatic send_beat(input logic [31:0] d);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (in_ready !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      if (in_ready !== 1'b1) begin
         n_cmp++;
         n_err++;
         $error("FAIL beat_timeout: observed in_ready=%b expected 1", in_ready);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic take_result(input string tag, input logic [31:0] exp);
      check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_out_data"},  out_data, exp);
      check({tag, "_in_ready_hold"}, {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_out_valid_clr"}, {31'b0, out_valid}, 32'd0);
      check({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
      check({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
   endtask

   // Sends pat[0..8]; optionally idles a few cycles after beat index pause_after.
   task automatic run_window(input string tag, input logic [31:0] exp, input int pause_after);
      for (int i = 0; i < 9; i++) begin
         send_beat(pat[i]);
         if (i == 0) check({tag, "_busy"}, {31'b0, busy}, 32'd1);
         if (i == pause_after) begin
            repeat (3) step();
            check({tag, "_pause_valid"}, {31'b0, out_valid}, 32'd0);
            check({tag, "_pause_busy"}, {31'b0, busy}, 32'd1);
         end
      end
      take_result(tag, exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;
      step();
      step();
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data",  out_data, 32'h0);
      check("rst_busy",      {31'b0, busy}, 32'd0);
      check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;
      step();

      // Nine +1.0 beats.
      pat = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
              32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
      run_window("ones", 32'h00090000, -1);

      // +2.5 and -4.0 with zeros, paused mid-window.
      pat = '{32'h00028000, 32'h00000000, 32'h80040000, 32'h00000000, 32'h00000000,
              32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
`ifdef CONV_ACC_RELU_EN
      run_window("neg1p5", 32'h00000000, 3);
`else
      run_window("neg1p5", 32'h80018000, 3);
`endif

      // +1, -1 and -0 cancelling to zero: must be +0.
      pat = '{32'h00010000, 32'h80010000, 32'h80000000, 32'h00010000, 32'h80010000,
              32'h80000000, 32'h00010000, 32'h80010000, 32'h80000000};
      run_window("zero", 32'h00000000, -1);

      // Positive saturation.
      pat = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
              32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
      run_window("sat_pos", 32'h7FFFFFFF, -1);

      // One LSB past full scale still saturates.
      pat = '{32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000,
              32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
      run_window("sat_edge", 32'h7FFFFFFF, -1);

      // Negative saturation.
      pat = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
`ifdef CONV_ACC_RELU_EN
      run_window("sat_neg", 32'h00000000, -1);
`else
      run_window("sat_neg", 32'hFFFFFFFF, -1);
`endif

      // Backpressure: nine +2.0 beats, then hold result 5 cycles with input pending.
      for (int i = 0; i < 9; i++) send_beat(32'h00020000);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_out_data",  out_data, 32'h00120000);
      in_valid = 1'b1;
      in_data  = 32'h00010000;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_valid",    {31'b0, out_valid}, 32'd1);
         check("bp_hold_data",     out_data, 32'h00120000);
         check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_hold_busy",     {31'b0, busy}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_handoff_valid",    {31'b0, out_valid}, 32'd0);
      check("bp_handoff_in_ready", {31'b0, in_ready}, 32'd1);
      check("bp_handoff_busy",     {31'b0, busy}, 32'd0);
      pat = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
              32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
      run_window("after_bp", 32'h00090000, -1);

      // Reset after four beats discards the partial sum.
      for (int i = 0; i < 4; i++) send_beat(32'h00010000);
      check("midrst_busy_pre", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      step();
      check("midrst_busy",      {31'b0, busy}, 32'd0);
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_out_data",  out_data, 32'h0);
      check("midrst_in_ready",  {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;
      step();
      run_window("post_rst", 32'h00090000, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_accumulator.md
Name: conv_accumulator

Overview:
- Downstream of the sign-magnitude fixed-point multiplier in the conv2d datapath.
- Consumes a stream of Q(DATA_WIDTH-FIXED_POINT).FIXED_POINT sign-magnitude products, one per accepted beat.
- Sums N_TERMS products, one full kernel window, then presents a single saturated sign-magnitude result on a valid/ready output.
- Restarts for the next window once that result has been taken.

Parameters:
- DATA_WIDTH, 32, word width; MSB is sign, remaining bits are magnitude.
- FIXED_POINT, 16, fractional bits. Format is only carried through; addition needs no rescale.
- N_TERMS, 9, products per window, >=1 (3x3 kernel).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  DATA_WIDTH  sign-magnitude product.
- out_valid  output  1  window result valid.
- out_ready  input  1  consumer takes result.
- out_data  output  DATA_WIDTH  sign-magnitude window sum.
- busy  output  1  high while partway through a window (count != 0).

Behaviour:
- Reset (rst_n low at a clk edge) clears everything:
  - state=ACCUM, count=0, accumulator=0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-window or mid-HOLD discards the partial sum or pending result.
- Internal accumulator: two's complement, ACC_W = DATA_WIDTH + clog2(N_TERMS) + 1 bits; cannot overflow internally.
- Input conversion: magnitude = in_data[DATA_WIDTH-2:0], zero-extended; negated when in_data[DATA_WIDTH-1]=1. Negative zero (0x80000000) adds 0.
- State ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc <= acc + term, count <= count+1.
  - On the beat with count==N_TERMS-1:
    - Final sum (acc+term) goes to the output register.
    - acc and count clear; out_valid <= 1; go to HOLD.
  - Latency: last beat accepted at edge t gives out_valid=1 after edge t (one cycle).
- State HOLD:
  - in_ready=0; input beats are not consumed.
  - out_data is stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready: out_valid <= 0, go to ACCUM; in_ready=1 the next cycle.
  - No same-cycle input acceptance on the handoff cycle.
- Output conversion:
  - sign = sum<0.
  - magnitude = |sum|, saturated to 2^(DATA_WIDTH-1)-1 when |sum| exceeds it.
  - Both positive and negative saturate symmetrically, i.e. 0x7FFFFFFF and 0xFFFFFFFF at default width.
  - A zero sum is always emitted as +0 (0x00000000), never -0.
- N_TERMS=1: every accepted beat produces a result, with normalisation and saturation still applied.
- in_valid low mid-window: accumulation pauses, with no timeout.
- busy = (count != 0).

Optional Feature:
- Macro CONV_ACC_RELU_EN.
- Defined: after saturation, any negative result is emitted as 0x00000000. Timing and handshake are unchanged.
- Not defined: negative results pass through in sign-magnitude form.
- The sum is full precision either way; ReLU applies only at output.

Test Plan:
- Nine beats of 0x00010000 (+1.0), out_ready=1 → one cycle after the 9th beat, out_valid=1, out_data=0x00090000, then in_ready=1.
- Beats +2.5 (0x00028000) and -4.0 (0x80040000), with seven 0x00000000 beats → out_data=0x80018000 (-1.5); with CONV_ACC_RELU_EN defined → 0x00000000.
- Mix of +1.0, -1.0 and -0 (0x80000000) summing to zero → out_data=0x00000000.
- Nine beats of 0x7FFFFFFF → out_data=0x7FFFFFFF. Nine beats of 0xFFFFFFFF → out_data=0xFFFFFFFF (0x00000000 with ReLU enabled).
- out_ready held low 5 cycles after a result, in_valid=1 throughout → out_data stable, in_ready=0, no beats consumed; the next window sum is correct after the handoff.
- rst_n asserted after 4 beats of +1.0 → outputs reset. Then 9 beats of +1.0 give 0x00090000, with no residue from before reset.
